// File: rtl/mem_access_unit.sv
// Load/store stage behind the 64-bit ALU: one request in flight, fixed-latency access to an
// internal doubleword RAM, valid/ready handshakes on request and response.
module mem_access_unit #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] direccion,
    input  logic [63:0] dato_escritura,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] dato_leido,
    output logic        error_acceso
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam int         DEPTH     = 1 << ADDR_W;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_pend_q, err_pend_d;
    logic [63:0]       dato_q, dato_d;
    logic              error_q, error_d;

    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [2:0]        lane_q, lane_d;
    logic [63:0]       wdata_q, wdata_d;

    logic [63:0]       mem [DEPTH];
    logic [63:0]       rd_word;
    logic [63:0]       lane_mask;
    logic [63:0]       wr_word;
    logic [5:0]        lane_sh;
    logic              misaligned;
    logic              out_of_range;
    logic              mem_we;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Doubleword loads pass through unchanged, so zero- and sign-extension agree there.
    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] size,
                                           input logic zext);
        case (size)
            2'b00:   extend = zext ? {56'd0, raw[7:0]}  : {{56{raw[7]}}, raw[7:0]};
            2'b01:   extend = zext ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'b10:   extend = zext ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: extend = raw;
        endcase
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = direccion[0];
            2'b10:   misaligned = |direccion[1:0];
            default: misaligned = |direccion[2:0];
        endcase
        out_of_range = |direccion[63:ADDR_W+3];
    end

    // Aligned accesses never straddle a doubleword, so one word read-modify-write suffices.
    assign lane_sh   = {lane_q, 3'b000};
    assign rd_word   = mem[idx_q];
    assign lane_mask = size_mask(size_q) << lane_sh;
    assign wr_word   = (rd_word & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        dato_d     = dato_q;
        error_d    = error_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        idx_d      = idx_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        mem_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    idx_d      = direccion[ADDR_W+2:3];
                    lane_d     = direccion[2:0];
                    wdata_d    = dato_escritura;
                    err_pend_d = misaligned | out_of_range;
                    cnt_d      = CNT_INIT;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Faulting requests skip the RAM and respond one cycle after acceptance.
                if (err_pend_q) begin
                    error_d = 1'b1;
                    dato_d  = 64'd0;
                    state_d = ST_RESP;
                end else if (cnt_q == 4'd0) begin
                    error_d = 1'b0;
                    state_d = ST_RESP;
                    if (write_q) begin
                        mem_we = 1'b1;
                        dato_d = 64'd0;
                    end else begin
                        dato_d = extend(rd_word >> lane_sh, size_q, unsigned_q);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            err_pend_q <= 1'b0;
            dato_q     <= 64'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            dato_q     <= dato_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q    <= write_d;
        size_q     <= size_d;
        unsigned_q <= unsigned_d;
        idx_q      <= idx_d;
        lane_q     <= lane_d;
        wdata_q    <= wdata_d;
    end

    // A reset during ACCESS forces IDLE at once, so an uncommitted store never reaches the RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wr_word;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign dato_leido   = dato_q;
    assign error_acceso = error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized loads/stores checked
// against a byte-array memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

    localparam int ADDR_W  = 8;
    localparam int LATENCY = 2;
    localparam logic [63:0] BYTE_SPACE = 64'd1 << (ADDR_W + 3);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [63:0] direccion = 64'd0;
    logic [63:0] dato_escritura = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] dato_leido;
    logic        error_acceso;

    int total = 0;
    int passed = 0;
    logic [7:0] model_b [0:2047];

    mem_access_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .direccion(direccion), .dato_escritura(dato_escritura),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .dato_leido(dato_leido), .error_acceso(error_acceso)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit model_err(input logic [63:0] a, input logic [1:0] sz);
        return ((a % 64'(nbytes(sz))) != 64'd0) || (a >= BYTE_SPACE);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [63:0] v;
        int n;
        v = 64'd0;
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = model_b[int'(a) + i];
        if (!uns && n < 8 && v[8*n-1]) begin
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] d);
        for (int i = 0; i < nbytes(sz); i++) model_b[int'(a) + i] = d[8*i +: 8];
    endtask

    // Entered and left at one time unit after a rising edge with the DUT idle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] d, input int hold,
                          input bit noise, output logic [63:0] rdata);
        int lat;
        bit exp_err;
        logic [63:0] exp_data;
        logic [63:0] held_data;
        logic held_err;
        exp_err  = model_err(a, sz);
        exp_data = (exp_err || w) ? 64'd0 : model_load(a, sz, uns);
        check("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        direccion = a; dato_escritura = d; resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("resp_latency", 64'(lat), exp_err ? 64'd1 : 64'(LATENCY));
        check("error_acceso", 64'(error_acceso), 64'(exp_err));
        check("dato_leido", dato_leido, exp_data);
        if (w && !exp_err) model_store(a, sz, d);
        rdata = dato_leido;
        held_data = dato_leido;
        held_err = error_acceso;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_dato", dato_leido, held_data);
            check("hold_error", 64'(error_acceso), 64'(held_err));
            if (noise) begin
                check("hold_req_ready", 64'(req_ready), 64'd0);
                req_valid = (k % 2 == 0);
                req_write = 1'b1; req_size = 2'b11; direccion = 64'h20;
                dato_escritura = {$urandom, $urandom};
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("resp_released", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] a;
        logic [63:0] d;
        logic [1:0] sz;
        logic w;
        logic uns;
        int acc[$];
        int guard;

        #1;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_dato", dato_leido, 64'd0);
        check("rst_error", 64'(error_acceso), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) do_req(1'b1, 2'b11, 1'b0, 64'(8 * i), {$urandom, $urandom}, 0, 0, rd);

        // T1: doubleword store then load
        do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122334455667788, 0, 0, rd);
        check("t1_store_dato", rd, 64'd0);
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 0, 0, rd);
        check("t1_load", rd, 64'h1122334455667788);

        // T2: byte store, signed/unsigned byte loads, merged doubleword
        do_req(1'b1, 2'b00, 1'b0, 64'h13, 64'h80, 0, 0, rd);
        do_req(1'b0, 2'b00, 1'b0, 64'h13, 64'd0, 0, 0, rd);
        check("t2_lb", rd, 64'hFFFFFFFFFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 64'h13, 64'd0, 0, 0, rd);
        check("t2_lbu", rd, 64'h80);
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 0, 0, rd);
        check("t2_ld", rd, 64'h1122334480667788);
        do_req(1'b0, 2'b11, 1'b1, 64'h10, 64'd0, 0, 0, rd);
        check("t2_ldu", rd, 64'h1122334480667788);

        // T3: misaligned load, out-of-range store leaves RAM untouched
        do_req(1'b0, 2'b01, 1'b0, 64'h11, 64'd0, 0, 0, rd);
        check("t3_misaligned_dato", rd, 64'd0);
        do_req(1'b1, 2'b10, 1'b0, 64'h2000, 64'hA5A5A5A5A5A5A5A5, 0, 0, rd);
        do_req(1'b0, 2'b11, 1'b0, 64'h0, 64'd0, 0, 0, rd);

        // T4: stalled response with requests toggling underneath
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 5, 1, rd);
        check("t4_dato", rd, 64'h1122334480667788);
        check("t4_idle_after", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        check("t4_no_accept", 64'(req_ready), 64'd1);
        do_req(1'b0, 2'b11, 1'b0, 64'h20, 64'd0, 0, 0, rd);

        // T5: reset during a store's access phase
        a = 64'h20;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; direccion = a;
        dato_escritura = 64'hDEAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_resp_valid", 64'(resp_valid), 64'd0);
        check("t5_dato", dato_leido, 64'd0);
        check("t5_error", 64'(error_acceso), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        do_req(1'b0, 2'b11, 1'b0, a, 64'd0, 0, 0, rd);
        check("t5_prior_kept", 64'(rd != 64'hDEAD), 64'd1);

        // T6: back-to-back loads with resp_ready held high
        req_write = 1'b0; req_size = 2'b11; req_unsigned = 1'b0; direccion = 64'h10;
        resp_ready = 1'b1; req_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (req_ready) acc.push_back(c);
            if (resp_valid) check("t6_dato", dato_leido, 64'h1122334480667788);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_drained", 64'(req_ready), 64'd1);
        check("t6_accepts", 64'(acc.size()), 64'd6);
        for (int i = 1; i < acc.size(); i++) check("t6_spacing", 64'(acc[i] - acc[i-1]), 64'(LATENCY + 2));

        // Randomized mix against the byte model
        for (int r = 0; r < 40; r++) begin
            w   = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) begin
                a = {$urandom, $urandom} | BYTE_SPACE;
            end else begin
                a = 64'($urandom_range(0, 127));
                if ($urandom_range(0, 3) != 0) a = a & ~64'(nbytes(sz) - 1);
            end
            do_req(w, sz, uns, a, d, $urandom_range(0, 2), 0, rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
